// File: rtl/cache_refill_ctrl.sv
// Cache line replacement sequencer: optional dirty write-back, then line refill from memory,
// driving the replace-side data-RAM port while holding the RAM select.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a request; read/write side owns the data RAM
// WB_RD     | present victim word address {set,cnt} to the RAM
// WB_CAP    | capture RAM read data into the write-back word register
// WB_SEND   | offer the victim word to memory, held until mem_wrReady
// RF_REQ    | refill burst request, held until mem_rdReqReady
// RF_DATA   | write each valid refill word straight into the RAM
// DONE      | one-cycle completion pulse, RAM still selected
module cache_refill_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int OFFSET_WIDTH = 3,
  localparam int SET_WIDTH   = ADDR_WIDTH - OFFSET_WIDTH,
  localparam int TAG_WIDTH   = 30 - ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SET_WIDTH-1:0]  req_set,
  input  logic [1:0]            req_way,
  input  logic                  req_dirty,
  input  logic [TAG_WIDTH-1:0]  req_victimTag,
  input  logic [TAG_WIDTH-1:0]  req_newTag,
  output logic                  done,
  output logic                  sel,
  output logic [1:0]            ri_rwChannel,
  output logic [ADDR_WIDTH-1:0] ri_readAddress,
  input  logic [31:0]           ri_readData,
  output logic [ADDR_WIDTH-1:0] ri_writeAddress,
  output logic                  ri_writeEnable,
  output logic [3:0]            ri_writeByteEnable,
  output logic [31:0]           ri_writeData,
  output logic                  mem_wrValid,
  input  logic                  mem_wrReady,
  output logic [31:0]           mem_wrAddress,
  output logic [31:0]           mem_wrData,
  output logic                  mem_wrLast,
  output logic                  mem_rdReqValid,
  input  logic                  mem_rdReqReady,
  output logic [31:0]           mem_rdAddress,
  input  logic                  mem_rdDataValid,
  input  logic [31:0]           mem_rdData
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WB_RD   = 3'd1,
    S_WB_CAP  = 3'd2,
    S_WB_SEND = 3'd3,
    S_RF_REQ  = 3'd4,
    S_RF_DATA = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [OFFSET_WIDTH-1:0] r_cnt;
  logic [SET_WIDTH-1:0]    r_set;
  logic [1:0]              r_way;
  logic [TAG_WIDTH-1:0]    r_victim_tag;
  logic [TAG_WIDTH-1:0]    r_new_tag;
  logic [31:0]             r_wb_data;
  logic                    w_cnt_last;

  assign w_cnt_last = &r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_set        <= '0;
      r_way        <= '0;
      r_victim_tag <= '0;
      r_new_tag    <= '0;
      r_wb_data    <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_set        <= req_set;
            r_way        <= req_way;
            r_victim_tag <= req_victimTag;
            r_new_tag    <= req_newTag;
            r_cnt        <= '0;
          end
        end
        S_WB_CAP: r_wb_data <= ri_readData;
        S_WB_SEND: begin
          if (mem_wrReady) r_cnt <= w_cnt_last ? '0 : r_cnt + OFFSET_WIDTH'(1);
        end
        // the increment after the last word lands back on zero, leaving cnt clean for DONE
        S_RF_DATA: begin
          if (mem_rdDataValid) r_cnt <= r_cnt + OFFSET_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (req_valid) w_next_state = req_dirty ? S_WB_RD : S_RF_REQ;
      S_WB_RD:   w_next_state = S_WB_CAP;
      S_WB_CAP:  w_next_state = S_WB_SEND;
      S_WB_SEND: if (mem_wrReady) w_next_state = w_cnt_last ? S_RF_REQ : S_WB_RD;
      S_RF_REQ:  if (mem_rdReqReady) w_next_state = S_RF_DATA;
      S_RF_DATA: if (mem_rdDataValid && w_cnt_last) w_next_state = S_DONE;
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready          = 1'b0;
    done               = 1'b0;
    sel                = 1'b1;
    ri_rwChannel       = r_way;
    ri_readAddress     = '0;
    ri_writeAddress    = '0;
    ri_writeEnable     = 1'b0;
    ri_writeByteEnable = 4'h0;
    ri_writeData       = '0;
    mem_wrValid        = 1'b0;
    mem_wrAddress      = '0;
    mem_wrData         = '0;
    mem_wrLast         = 1'b0;
    mem_rdReqValid     = 1'b0;
    mem_rdAddress      = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        sel       = 1'b0;
      end
      S_WB_RD, S_WB_CAP: ri_readAddress = {r_set, r_cnt};
      S_WB_SEND: begin
        ri_readAddress = {r_set, r_cnt};
        mem_wrValid    = 1'b1;
        mem_wrAddress  = {r_victim_tag, r_set, r_cnt, 2'b00};
        mem_wrData     = r_wb_data;
        mem_wrLast     = w_cnt_last;
      end
      S_RF_REQ: begin
        mem_rdReqValid = 1'b1;
        mem_rdAddress  = {r_new_tag, r_set, {OFFSET_WIDTH{1'b0}}, 2'b00};
      end
      S_RF_DATA: begin
        ri_writeAddress    = {r_set, r_cnt};
        ri_writeEnable     = mem_rdDataValid;
        ri_writeByteEnable = mem_rdDataValid ? 4'hF : 4'h0;
        ri_writeData       = mem_rdDataValid ? mem_rdData : 32'h0;
      end
      S_DONE: done = 1'b1;
      default: sel = 1'b0;
    endcase
  end

endmodule
